mem_responder: RTL and testbench

Memory-side responder for the L1 cache's line interface. Accepts one 128-bit line read or write per request from the cache and completes it against a 32-bit-wide single-port synchronous SRAM, four words per line. Returns a single-cycle `mem_ready` pulse to finish each request. Sits between the L1 cache and the backing store, replacing the behavioural memory model in synthesizable builds.

---
 rtl/mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_mem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the L1 cache line interface. Each accepted
//   request moves one 128-bit line to or from a 32-bit single-port synchronous
//   SRAM as four word beats, and the request finishes with a one-cycle
//   mem_ready pulse.
//
//   Flow: IDLE -> (WAIT for LAT cycles, only if LAT > 0) -> WR or RD -> DONE -> IDLE
//
// Parameters
//   LAT      extra wait cycles before each SRAM access sequence (0 allowed)
//   SRAM_AW  SRAM word-address width; the SRAM holds 2^(SRAM_AW-2) lines
//
// Ports
//   clk, proc_reset_n      rising-edge clock; asynchronous active-low reset
//   mem_read, mem_write    line requests, held high until mem_ready
//   mem_addr, mem_wdata    line address and write line (word k = [32k+31:32k])
//   mem_rdata, mem_ready   read line (held between reads); completion pulse
//   sram_cs, sram_we,
//   sram_addr, sram_wdata  SRAM access port; address and data are 0 while cs=0
//   sram_rdata             SRAM read word, valid the cycle after a read access
//   proto_err              sticky protocol-error flag
//
// Handshake: a request is sampled only in IDLE. The requester keeps its
// request line and mem_addr stable until it sees mem_ready=1. The still-high
// request during DONE is not re-accepted. A new request may be raised in the
// cycle right after DONE and is accepted in that cycle.
//
// Optional feature: define MEM_RESP_PROTO_CHK_EN to build the protocol checker
// that drives proto_err. Otherwise proto_err is tied to 0.
module mem_responder #(
  parameter int LAT     = 4,
  parameter int SRAM_AW = 10
) (
  input  logic                clk,
  input  logic                proc_reset_n,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [27:0]         mem_addr,
  input  logic [127:0]        mem_wdata,
  output logic [127:0]        mem_rdata,
  output logic                mem_ready,
  output logic                sram_cs,
  output logic                sram_we,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [31:0]         sram_wdata,
  input  logic [31:0]         sram_rdata,
  output logic                proto_err
);

  typedef enum logic [2:0] {IDLE, WAIT, WR, RD, DONE} state_t;

  localparam logic [15:0] LAT_M1 = (LAT > 0) ? 16'(LAT - 1) : 16'd0;

  state_t         state, state_nx;
  logic [2:0]     beat, beat_nx;     // RD uses beat 4 as the capture-only cycle
  logic [15:0]    cnt, cnt_nx;
  logic           is_wr;
  logic [27:0]    addr_q;
  logic [127:0]   wdata_q;
  logic           accept;
  logic           issue_rd;
  logic           cap_en;            // a read word arrives on sram_rdata this cycle
  logic [1:0]     cap_idx;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state     <= IDLE;
      beat      <= '0;
      cnt       <= '0;
      is_wr     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cap_en    <= 1'b0;
      cap_idx   <= '0;
      mem_rdata <= '0;
    end else begin
      state   <= state_nx;
      beat    <= beat_nx;
      cnt     <= cnt_nx;
      cap_en  <= issue_rd;
      cap_idx <= beat[1:0];
      if (accept) begin
        is_wr  <= mem_write;
        addr_q <= mem_addr;
        if (mem_write) wdata_q <= mem_wdata;
      end
      if (cap_en) begin
        for (int k = 0; k < 4; k++) begin
          if (cap_idx == 2'(k)) mem_rdata[32*k +: 32] <= sram_rdata;
        end
      end
    end
  end

  always_comb begin
    state_nx   = state;
    beat_nx    = beat;
    cnt_nx     = cnt;
    accept     = 1'b0;
    issue_rd   = 1'b0;
    mem_ready  = 1'b0;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state)
      IDLE: begin
        if (mem_write || mem_read) begin
          accept  = 1'b1;
          beat_nx = '0;
          if (LAT > 0) begin
            state_nx = WAIT;
            cnt_nx   = LAT_M1;
          end else begin
            state_nx = mem_write ? WR : RD;
          end
        end
      end
      WAIT: begin
        if (cnt == 16'd0) state_nx = is_wr ? WR : RD;
        else              cnt_nx   = cnt - 16'd1;
      end
      WR: begin
        sram_cs   = 1'b1;
        sram_we   = 1'b1;
        sram_addr = {addr_q[SRAM_AW-3:0], beat[1:0]};
        case (beat[1:0])
          2'd0:    sram_wdata = wdata_q[31:0];
          2'd1:    sram_wdata = wdata_q[63:32];
          2'd2:    sram_wdata = wdata_q[95:64];
          default: sram_wdata = wdata_q[127:96];
        endcase
        if (beat == 3'd3) begin
          state_nx = DONE;
          beat_nx  = '0;
        end else begin
          beat_nx = beat + 3'd1;
        end
      end
      RD: begin
        if (beat < 3'd4) begin
          sram_cs   = 1'b1;
          sram_addr = {addr_q[SRAM_AW-3:0], beat[1:0]};
          issue_rd  = 1'b1;
          beat_nx   = beat + 3'd1;
        end else begin
          // Capture-only cycle: the last word lands in mem_rdata at this edge.
          state_nx = DONE;
          beat_nx  = '0;
        end
      end
      DONE: begin
        mem_ready = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef MEM_RESP_PROTO_CHK_EN
  logic busy;
  logic req_drop;
  logic addr_chg;
  logic both_req;

  assign busy     = (state != IDLE);
  assign req_drop = ((state == WAIT) || (state == WR) || (state == RD)) &&
                    (is_wr ? !mem_write : !mem_read);
  assign addr_chg = busy && (mem_addr != addr_q);
  assign both_req = mem_read && mem_write;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) proto_err <= 1'b0;
    else if (both_req || req_drop || addr_chg) proto_err <= 1'b1;
  end
`else
  // Upper address bits only feed the checker; without it they are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_q[27:SRAM_AW-2];
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. Two instances share clock and reset:
// dut_a with LAT=4 and dut_b with LAT=0. Each has a behavioural SRAM.
// Cycle 0 is the cycle in which a request is first driven. Outputs are sampled
// on the falling edge.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         rd_a, wr_a, ready_a, cs_a, we_a, perr_a;
  logic [27:0]  addr_a;
  logic [127:0] wdata_a, rdata_a;
  logic [9:0]   saddr_a;
  logic [31:0]  swdata_a, srdata_a;

  logic         rd_b, wr_b, ready_b, cs_b, we_b, perr_b;
  logic [27:0]  addr_b;
  logic [127:0] wdata_b, rdata_b;
  logic [9:0]   saddr_b;
  logic [31:0]  swdata_b, srdata_b;

  mem_responder #(.LAT(4), .SRAM_AW(10)) dut_a (
    .clk(clk), .proc_reset_n(rst_n), .mem_read(rd_a), .mem_write(wr_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a),
    .mem_ready(ready_a), .sram_cs(cs_a), .sram_we(we_a), .sram_addr(saddr_a),
    .sram_wdata(swdata_a), .sram_rdata(srdata_a), .proto_err(perr_a)
  );

  mem_responder #(.LAT(0), .SRAM_AW(10)) dut_b (
    .clk(clk), .proc_reset_n(rst_n), .mem_read(rd_b), .mem_write(wr_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
    .mem_ready(ready_b), .sram_cs(cs_b), .sram_we(we_b), .sram_addr(saddr_b),
    .sram_wdata(swdata_b), .sram_rdata(srdata_b), .proto_err(perr_b)
  );

  // Behavioural synchronous SRAMs
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  always @(posedge clk) begin
    if (cs_a) begin
      if (we_a) mem_a[saddr_a] <= swdata_a;
      else      srdata_a <= mem_a[saddr_a];
    end
  end
  always @(posedge clk) begin
    if (cs_b) begin
      if (we_b) mem_b[saddr_b] <= swdata_b;
      else      srdata_b <= mem_b[saddr_b];
    end
  end

  // Scoreboard: SRAM write beats as {cycle[15:0], 6'b0, addr[9:0], data[31:0]}
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] LINE1 = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
  localparam logic [127:0] LINE2 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] LINE3 = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
  localparam logic [127:0] LINE4 = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
  localparam logic [127:0] LINE5 = {32'hA5A5_0100, 32'h5A5A_0100, 32'hF00D_0100, 32'hBEEF_0100};

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drives a request in the current cycle (cycle 0) and samples every cycle
  // until mem_ready. The request stays high; rdy is -1 on timeout.
  task automatic run_req(input bit sel, input bit wr, input bit rd,
                         input logic [27:0] addr, input logic [127:0] wd,
                         output int rdy);
    rdy = -1;
    if (!sel) begin wr_a = wr; rd_a = rd; addr_a = addr; wdata_a = wd; end
    else      begin wr_b = wr; rd_b = rd; addr_b = addr; wdata_b = wd; end
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (!sel) begin
        if (cs_a && we_a) obs_q.push_back({16'(c), 6'b0, saddr_a, swdata_a});
        if (ready_a) begin rdy = c; break; end
      end else begin
        if (cs_b && we_b) obs_q.push_back({16'(c), 6'b0, saddr_b, swdata_b});
        if (ready_b) begin rdy = c; break; end
      end
    end
  endtask

  task automatic release_req(input bit sel);
    @(negedge clk);
    if (!sel) begin wr_a = 1'b0; rd_a = 1'b0; end
    else      begin wr_b = 1'b0; rd_b = 1'b0; end
  endtask

  task automatic expect_line_writes(input int first_cyc, input logic [9:0] base,
                                    input logic [127:0] line);
    for (int b = 0; b < 4; b++)
      exp_q.push_back({16'(first_cyc + b), 6'b0, base + 10'(b), line[32*b +: 32]});
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check(tag, 128'(obs_q.pop_front()), 128'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
  endtask

  int  r;
  bit  seen_ready;

  initial begin
    rst_n = 1'b0;
    rd_a = 0; wr_a = 0; addr_a = '0; wdata_a = '0;
    rd_b = 0; wr_b = 0; addr_b = '0; wdata_b = '0;

    // Reset held with random request traffic
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd_a = 1'($urandom); wr_a = 1'($urandom); addr_a = 28'($urandom);
      wdata_a = {$urandom, $urandom, $urandom, $urandom};
      rd_b = 1'($urandom); wr_b = 1'($urandom); addr_b = 28'($urandom);
      wdata_b = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check("rst_ctl_a", 128'({ready_a, cs_a, we_a, perr_a, saddr_a, swdata_a}), 128'd0);
      check("rst_rdata_a", rdata_a, 128'd0);
      check("rst_ctl_b", 128'({ready_b, cs_b, we_b, perr_b, saddr_b, swdata_b}), 128'd0);
      check("rst_rdata_b", rdata_b, 128'd0);
    end
    @(negedge clk);
    rd_a = 0; wr_a = 0; addr_a = '0; wdata_a = '0;
    rd_b = 0; wr_b = 0; addr_b = '0; wdata_b = '0;
    rst_n = 1'b1;
    @(negedge clk);

    // Write line 5 with LAT=4
    expect_line_writes(5, 10'd20, LINE1);
    run_req(0, 1, 0, 28'h0000005, LINE1, r);
    check("wr_ready_cyc", 128'(r), 128'd9);
    compare_writes("wr_beat");
    release_req(0);
    @(negedge clk);

    // Readback
    run_req(0, 0, 1, 28'h0000005, '0, r);
    check("rd_ready_cyc", 128'(r), 128'd10);
    check("rd_data", rdata_a, LINE1);
    compare_writes("rd_no_write");
    release_req(0);

    // A write leaves mem_rdata untouched
    @(negedge clk);
    run_req(0, 1, 0, 28'h0000006, LINE2, r);
    check("wr2_ready_cyc", 128'(r), 128'd9);
    release_req(0);
    @(negedge clk);
    check("rdata_hold", rdata_a, LINE1);
    obs_q.delete();

    // Eviction pattern on LAT=0: write line 3, read line 7 back to back
    run_req(1, 1, 0, 28'h0000007, LINE3, r);
    release_req(1);
    obs_q.delete();
    @(negedge clk);
    expect_line_writes(1, 10'd12, LINE4);
    run_req(1, 1, 0, 28'h0000003, LINE4, r);
    check("evict_wr_ready_cyc", 128'(r), 128'd5);
    compare_writes("evict_wr_beat");
    @(negedge clk);
    run_req(1, 0, 1, 28'h0000007, '0, r);
    check("refill_ready_cyc", 128'(r), 128'd6);
    check("refill_data", rdata_b, LINE3);
    release_req(1);

    // Aliasing: line 0x100 and line 0x000 share SRAM storage
    @(negedge clk);
    expect_line_writes(5, 10'd0, LINE5);
    run_req(0, 1, 0, 28'h0000100, LINE5, r);
    compare_writes("alias_wr_beat");
    release_req(0);
    @(negedge clk);
    run_req(0, 0, 1, 28'h0000000, '0, r);
    check("alias_rd_data", rdata_a, LINE5);
    release_req(0);

    // Reset during RD beat 2
    @(negedge clk);
    seen_ready = 1'b0;
    rd_a = 1'b1; addr_a = 28'h0000005;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      seen_ready |= ready_a;
    end
    check("abort_beat2", 128'({cs_a, we_a, saddr_a}), 128'({1'b1, 1'b0, 10'd22}));
    rst_n = 1'b0;
    #1;
    check("abort_outs", 128'({ready_a, cs_a, we_a, saddr_a, swdata_a}), 128'd0);
    check("abort_rdata", rdata_a, 128'd0);
    @(negedge clk);
    rd_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      seen_ready |= ready_a;
    end
    check("abort_no_ready", 128'(seen_ready), 128'd0);
    run_req(0, 0, 1, 28'h0000005, '0, r);
    check("post_abort_ready_cyc", 128'(r), 128'd10);
    check("post_abort_data", rdata_a, LINE1);
    release_req(0);
    obs_q.delete();

`ifdef MEM_RESP_PROTO_CHK_EN
    @(negedge clk);
    check("proto_clean", 128'(perr_b), 128'd0);
    run_req(1, 1, 1, 28'h0000009, LINE4, r);
    check("both_ready_cyc", 128'(r), 128'd5);
    check("proto_set", 128'(perr_b), 128'd1);
    release_req(1);
    @(negedge clk);
    check("proto_sticky", 128'(perr_b), 128'd1);
    rst_n = 1'b0;
    #1;
    check("proto_rst", 128'(perr_b), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    @(negedge clk);
    wr_b = 1'b1; rd_b = 1'b1; addr_b = 28'h0000009;
    @(negedge clk);
    check("proto_tied_a", 128'(perr_a), 128'd0);
    check("proto_tied_b", 128'(perr_b), 128'd0);
    wr_b = 1'b0; rd_b = 1'b0;
    repeat (8) @(negedge clk);
`endif
    obs_q.delete();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
